// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives rows one at a time, synchronizes the columns,
// and debounces press and release before presenting the key as one-hot rows/columns.
module keypad_scanner #(
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col_in,
   output logic [3:0] row_drive,
   output logic [3:0] rows,
   output logic [3:0] columns,
   output logic       key_pulse
);
   localparam int MAX_COUNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int CW        = $clog2(MAX_COUNT);
   localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE_P, HELD, RELEASE} state_t;

   state_t        state;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    col_s;
   logic [1:0]    row_idx;
   logic [CW-1:0] count;
   logic [3:0]    lat_col;
   logic          col_single;
   logic          lat_hit;

   // Synchronizer resets to the idle (pulled-up) level so no phantom key appears.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 4'hF;
         sync2 <= 4'hF;
      end else begin
         sync1 <= col_in;
         sync2 <= sync1;
      end
   end

   assign col_s      = ~sync2;
   assign col_single = (col_s != 4'd0) && ((col_s & (col_s - 4'd1)) == 4'd0);
   assign lat_hit    = |(col_s & lat_col);
   assign row_drive  = ~(4'b0001 << row_idx);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= SCAN;
         row_idx   <= 2'd0;
         count     <= '0;
         lat_col   <= 4'd0;
         rows      <= 4'd0;
         columns   <= 4'd0;
         key_pulse <= 1'b0;
      end else begin
         key_pulse <= 1'b0;
         case (state)
            SCAN: begin
               if (count == DWELL_LAST) begin
                  count <= '0;
                  if (col_single) begin
                     lat_col <= col_s;
                     state   <= DEBOUNCE_P;
                  end else begin
                     row_idx <= row_idx + 2'd1;
                  end
               end else begin
                  count <= count + CW'(1);
               end
            end
            DEBOUNCE_P: begin
               if (col_s != lat_col) begin
                  state   <= SCAN;
                  row_idx <= row_idx + 2'd1;
                  count   <= '0;
               end else if (count == DEB_LAST) begin
                  state     <= HELD;
                  count     <= '0;
                  rows      <= 4'b0001 << row_idx;
                  columns   <= lat_col;
                  key_pulse <= 1'b1;
               end else begin
                  count <= count + CW'(1);
               end
            end
            // Only the latched column matters while held; other keys are ignored.
            HELD: begin
               if (!lat_hit) begin
                  state <= RELEASE;
                  count <= '0;
               end
            end
            RELEASE: begin
               if (lat_hit) begin
                  state <= HELD;
               end else if (count == DEB_LAST) begin
                  state   <= SCAN;
                  row_idx <= row_idx + 2'd1;
                  count   <= '0;
                  rows    <= 4'd0;
                  columns <= 4'd0;
               end else begin
                  count <= count + CW'(1);
               end
            end
            default: state <= SCAN;
         endcase
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a simulated keypad matrix responds to
// row_drive, and a run-length reference model predicts every output each cycle.
module tb_keypad_scanner;
   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] col_in = 4'hF;
   logic [3:0] row_drive;
   logic [3:0] rows;
   logic [3:0] columns;
   logic       key_pulse;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk       (clk),
      .reset     (reset),
      .col_in    (col_in),
      .row_drive (row_drive),
      .rows      (rows),
      .columns   (columns),
      .key_pulse (key_pulse)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int dut_pulses = 0;
   logic [15:0] pressed = 16'd0;   // bit r*4+c = key at row r, column c is down

   // Reference model: the column view lags the pins by two edges; a press is
   // accepted after DEB+1 consecutive matching samples starting at the scan
   // sample, a release after DEB+1 consecutive samples without the column.
   logic [3:0] hist[$];
   int         m_mode;             // 0 scanning, 1 confirming press, 2 key accepted
   int         m_row, m_dwell, m_run, m_absent;
   logic [3:0] m_cand, m_rows, m_cols;
   logic       m_pulse;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      hist = {4'hF, 4'hF};
      m_mode = 0; m_row = 0; m_dwell = 0; m_run = 0; m_absent = 0;
      m_cand = 4'd0; m_rows = 4'd0; m_cols = 4'd0; m_pulse = 1'b0;
   endtask

   task automatic model_edge(input logic [3:0] raw);
      logic [3:0] cs;
      cs = ~hist.pop_front();
      hist.push_back(raw);
      m_pulse = 1'b0;
      if (m_mode == 0) begin
         if (m_dwell == SCAN_DIV - 1) begin
            m_dwell = 0;
            if ($countones(cs) == 1) begin
               m_cand = cs; m_run = 1; m_mode = 1;
            end else begin
               m_row = (m_row + 1) % 4;
            end
         end else begin
            m_dwell++;
         end
      end else if (m_mode == 1) begin
         if (cs != m_cand) begin
            m_mode = 0; m_row = (m_row + 1) % 4; m_dwell = 0;
         end else begin
            m_run++;
            if (m_run == DEB + 1) begin
               m_mode = 2; m_rows = 4'(1 << m_row); m_cols = m_cand;
               m_pulse = 1'b1; m_absent = 0;
            end
         end
      end else begin
         if ((cs & m_cand) != 4'd0) begin
            m_absent = 0;
         end else begin
            m_absent++;
            if (m_absent == DEB + 1) begin
               m_mode = 0; m_row = (m_row + 1) % 4; m_dwell = 0;
               m_rows = 4'd0; m_cols = 4'd0;
            end
         end
      end
   endtask

   task automatic drive_cols();
      logic [3:0] c;
      c = 4'hF;
      for (int r = 0; r < 4; r++)
         if (!row_drive[r])
            for (int k = 0; k < 4; k++)
               if (pressed[r*4+k]) c[k] = 1'b0;
      col_in = c;
   endtask

   task automatic compare_all();
      logic [3:0] e_rd;
      e_rd = ~(4'b0001 << m_row);
      check("row_drive", row_drive, e_rd);
      check("rows", rows, m_rows);
      check("columns", columns, m_cols);
      check("key_pulse", {3'd0, key_pulse}, {3'd0, m_pulse});
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) model_reset();
      else model_edge(col_in);
      #1;
      if (key_pulse) dut_pulses++;
      compare_all();
      drive_cols();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_clear(input string tag);
      int n;
      n = 0;
      while (rows != 4'd0 && n < 40) begin
         tick();
         n++;
      end
      check(tag, rows, 4'd0);
   endtask

   initial begin
      int p0;
      model_reset();

      // Reset state
      #1;
      check("reset_row_drive", row_drive, 4'b1110);
      check("reset_rows", rows, 4'd0);
      run(3);
      reset = 1'b1;
      $display("step reset: row_drive=%b rows=%b columns=%b", row_drive, rows, columns);

      // Idle scan
      p0 = dut_pulses;
      run(40);
      check_int("idle_pulses", dut_pulses - p0, 0);
      $display("step idle scan: row_drive=%b pulses=%0d", row_drive, dut_pulses - p0);

      // Clean press row 2 / column 1
      p0 = dut_pulses;
      pressed = 16'd1 << 9;
      run(100);
      check_int("clean_pulses", dut_pulses - p0, 1);
      check("clean_rows", rows, 4'b0100);
      check("clean_columns", columns, 4'b0010);
      pressed = 16'd0;
      wait_clear("clean_clear");
      check("clean_resume_row3", row_drive, 4'b0111);
      check("clean_columns_clear", columns, 4'd0);
      $display("step clean press: pulses=%0d row_drive=%b", dut_pulses - p0, row_drive);

      // Bouncy press row 1 / column 3
      p0 = dut_pulses;
      for (int i = 0; i < 20; i++) begin
         pressed = ((i / 3) % 2 == 0) ? (16'd1 << 7) : 16'd0;
         tick();
      end
      check_int("bounce_no_pulse", dut_pulses - p0, 0);
      pressed = 16'd1 << 7;
      run(50);
      check_int("bounce_one_pulse", dut_pulses - p0, 1);
      check("bounce_rows", rows, 4'b0010);
      check("bounce_columns", columns, 4'b1000);
      pressed = 16'd0;
      wait_clear("bounce_clear");
      $display("step bouncy press: pulses=%0d", dut_pulses - p0);

      // Release bounce on row 0 / column 0
      p0 = dut_pulses;
      pressed = 16'd1;
      run(60);
      pressed = 16'd0;
      run(4);
      pressed = 16'd1;
      run(6);
      check("relbounce_rows_kept", rows, 4'b0001);
      check("relbounce_cols_kept", columns, 4'b0001);
      pressed = 16'd0;
      wait_clear("relbounce_clear");
      check_int("relbounce_pulses", dut_pulses - p0, 1);
      $display("step release bounce: pulses=%0d", dut_pulses - p0);

      // Two columns in one row, then a second key while one is held
      p0 = dut_pulses;
      pressed = (16'd1 << 4) | (16'd1 << 5);
      run(40);
      check_int("twocol_no_pulse", dut_pulses - p0, 0);
      check("twocol_rows", rows, 4'd0);
      pressed = 16'd1 << 9;
      run(60);
      pressed = pressed | (16'd1 << 8) | (16'd1 << 14);
      run(30);
      check("second_rows", rows, 4'b0100);
      check("second_columns", columns, 4'b0010);
      check_int("second_pulses", dut_pulses - p0, 1);
      pressed = 16'd0;
      wait_clear("second_clear");
      $display("step multi-key: pulses=%0d", dut_pulses - p0);

      // Asynchronous reset while held, then a fresh debounce of the same key
      pressed = 16'd1 << 13;
      run(60);
      check("prereset_rows", rows, 4'b1000);
      reset = 1'b0;
      #1;
      check("async_row_drive", row_drive, 4'b1110);
      check("async_rows", rows, 4'd0);
      check("async_columns", columns, 4'd0);
      check("async_pulse", {3'd0, key_pulse}, 4'd0);
      model_reset();
      drive_cols();
      run(3);
      reset = 1'b1;
      p0 = dut_pulses;
      run(60);
      check_int("postreset_pulses", dut_pulses - p0, 1);
      check("postreset_rows", rows, 4'b1000);
      check("postreset_columns", columns, 4'b0010);
      pressed = 16'd0;
      wait_clear("postreset_clear");
      $display("step reset mid-held: pulses=%0d", dut_pulses - p0);

      // Randomized presses with bounce and stray keys
      for (int t = 0; t < 20; t++) begin
         int k;
         k = int'($urandom_range(0, 15));
         p0 = dut_pulses;
         for (int i = 0; i < int'($urandom_range(0, 12)); i++) begin
            pressed = ($urandom_range(0, 1) == 1) ? (16'd1 << k) : 16'd0;
            tick();
         end
         pressed = 16'd1 << k;
         if ($urandom_range(0, 3) == 0) pressed = pressed | (16'd1 << $urandom_range(0, 15));
         run(int'($urandom_range(20, 80)));
         pressed = 16'd0;
         run(30);
         $display("step random %0d: key=%0d pulses=%0d", t, k, dut_pulses - p0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
